regfile_debug_sequencer: RTL and testbench

//   Initiator-side engine that drives the register file's read port 1 and write port 3 on behalf of
//   a debug/test host. Accepts one command at a time: single read, single write, dump-all, clear-all.

---
 rtl/regfile_debug_sequencer.sv | 172 +++++++++++++++++
 tb/tb_regfile_debug_sequencer.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_debug_sequencer.sv
// ============================================================================
// Module   : regfile_debug_sequencer
// Purpose  : Debug-host engine that reads and writes the register file through
//            read port 1 and write port 3. Read data goes back over a
//            valid/ready response channel.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module regfile_debug_sequencer #(
    parameter int NREGS = 32,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_cmd_valid,
    output logic          o_cmd_ready,
    input  logic [1:0]    i_cmd_op,
    input  logic [AW-1:0] i_cmd_addr,
    input  logic [DW-1:0] i_cmd_data,
    output logic          o_rsp_valid,
    input  logic          i_rsp_ready,
    output logic [AW-1:0] o_rsp_addr,
    output logic [DW-1:0] o_rsp_data,
    output logic          o_rsp_last,
    output logic [AW-1:0] o_rf_a1,
    input  logic [DW-1:0] i_rf_rd1,
    output logic          o_rf_we3,
    output logic [AW-1:0] o_rf_a3,
    output logic [DW-1:0] o_rf_wd3,
    output logic          o_busy
);

    localparam logic [1:0]    c_OP_READ  = 2'b00;
    localparam logic [1:0]    c_OP_WRITE = 2'b01;
    localparam logic [1:0]    c_OP_DUMP  = 2'b10;
    localparam logic [1:0]    c_OP_CLEAR = 2'b11;
    localparam logic [AW-1:0] c_LAST_IDX = AW'(NREGS - 1);
    localparam logic [AW-1:0] c_IDX_ONE  = AW'(1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD_ISSUE = 3'd1,
        S_RD_WAIT  = 3'd2,
        S_WR       = 3'd3,
        S_CLR      = 3'd4
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [AW-1:0] r_idx, w_idx_nxt;
    logic [1:0]    r_op, w_op_nxt;
    logic [DW-1:0] r_data, w_data_nxt;
    logic          r_rsp_valid, w_rsp_valid_nxt;
    logic          r_rsp_last, w_rsp_last_nxt;
    logic [AW-1:0] r_rsp_addr, w_rsp_addr_nxt;
    logic [DW-1:0] r_rsp_data, w_rsp_data_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_op        <= c_OP_READ;
            r_data      <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_last  <= 1'b0;
            r_rsp_addr  <= '0;
            r_rsp_data  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_op        <= w_op_nxt;
            r_data      <= w_data_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_last  <= w_rsp_last_nxt;
            r_rsp_addr  <= w_rsp_addr_nxt;
            r_rsp_data  <= w_rsp_data_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_op_nxt        = r_op;
        w_data_nxt      = r_data;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_last_nxt  = r_rsp_last;
        w_rsp_addr_nxt  = r_rsp_addr;
        w_rsp_data_nxt  = r_rsp_data;
        o_rf_a1         = '0;
        o_rf_we3        = 1'b0;
        o_rf_a3         = '0;
        o_rf_wd3        = '0;

        case (r_state)
            S_IDLE: begin
                if (i_cmd_valid) begin
                    w_op_nxt   = i_cmd_op;
                    w_data_nxt = i_cmd_data;
                    // idx doubles as the WRITE target address
                    case (i_cmd_op)
                        c_OP_READ: begin
                            w_idx_nxt   = i_cmd_addr;
                            w_state_nxt = S_RD_ISSUE;
                        end
                        c_OP_WRITE: begin
                            w_idx_nxt   = i_cmd_addr;
                            w_state_nxt = S_WR;
                        end
                        c_OP_DUMP: begin
                            w_idx_nxt   = '0;
                            w_state_nxt = S_RD_ISSUE;
                        end
                        default: begin
                            w_idx_nxt   = c_IDX_ONE;
                            w_state_nxt = S_CLR;
                        end
                    endcase
                end
            end
            S_RD_ISSUE: begin
                o_rf_a1         = r_idx;
                w_rsp_data_nxt  = i_rf_rd1;
                w_rsp_addr_nxt  = r_idx;
                w_rsp_valid_nxt = 1'b1;
                w_rsp_last_nxt  = (r_op == c_OP_READ) || (r_idx == c_LAST_IDX);
                w_state_nxt     = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                o_rf_a1 = r_idx;
                if (i_rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    if (r_rsp_last) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_idx_nxt   = r_idx + c_IDX_ONE;
                        w_state_nxt = S_RD_ISSUE;
                    end
                end
            end
            S_WR: begin
                o_rf_we3    = 1'b1;
                o_rf_a3     = r_idx;
                o_rf_wd3    = r_data;
                w_state_nxt = S_IDLE;
            end
            S_CLR: begin
                o_rf_we3 = 1'b1;
                o_rf_a3  = r_idx;
                // stop on the last index so idx never wraps back to 0
                if (r_idx == c_LAST_IDX) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_idx_nxt = r_idx + c_IDX_ONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign o_cmd_ready = (r_state == S_IDLE);
    assign o_busy      = ~o_cmd_ready;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_last  = r_rsp_last;
    assign o_rsp_addr  = r_rsp_addr;
    assign o_rsp_data  = r_rsp_data;

endmodule

`default_nettype wire

// File: tb/tb_regfile_debug_sequencer.sv
// ============================================================================
// Module   : tb_regfile_debug_sequencer
// Purpose  : Randomized scoreboard bench for regfile_debug_sequencer.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_regfile_debug_sequencer;

    localparam logic [1:0] c_READ  = 2'b00;
    localparam logic [1:0] c_WRITE = 2'b01;
    localparam logic [1:0] c_DUMP  = 2'b10;
    localparam logic [1:0] c_CLEAR = 2'b11;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready;
    logic [1:0]  cmd_op;
    logic [4:0]  cmd_addr;
    logic [31:0] cmd_data;
    logic        rsp_valid, rsp_ready, rsp_last;
    logic [4:0]  rsp_addr;
    logic [31:0] rsp_data;
    logic [4:0]  rf_a1, rf_a3;
    logic [31:0] rf_rd1, rf_wd3;
    logic        rf_we3, busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
        logic        l;
    } rsp_t;

    rsp_t        exp_q[$];
    logic [31:0] m_regs[32];
    logic [31:0] tb_rf[32];
    bit          rdy_rand = 0;

    bit          stall_prev = 0;
    logic [4:0]  p_a;
    logic [31:0] p_d;
    logic        p_l;

    always #5 clk = ~clk;

    regfile_debug_sequencer #(.NREGS(32), .AW(5), .DW(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .i_cmd_valid(cmd_valid),
        .o_cmd_ready(cmd_ready),
        .i_cmd_op   (cmd_op),
        .i_cmd_addr (cmd_addr),
        .i_cmd_data (cmd_data),
        .o_rsp_valid(rsp_valid),
        .i_rsp_ready(rsp_ready),
        .o_rsp_addr (rsp_addr),
        .o_rsp_data (rsp_data),
        .o_rsp_last (rsp_last),
        .o_rf_a1    (rf_a1),
        .i_rf_rd1   (rf_rd1),
        .o_rf_we3   (rf_we3),
        .o_rf_a3    (rf_a3),
        .o_rf_wd3   (rf_wd3),
        .o_busy     (busy)
    );

    // Register file the block is driving: x0 reads zero, writes land on the edge.
    assign rf_rd1 = (rf_a1 == 5'd0) ? 32'd0 : tb_rf[rf_a1];
    always @(posedge clk) begin
        if (rf_we3 && rf_a3 != 5'd0) tb_rf[rf_a3] <= rf_wd3;
    end

    initial begin
        rsp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rsp_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Reference model: command semantics on a plain array, responses queued.
    task automatic model_cmd(input logic [1:0] op, input logic [4:0] a, input logic [31:0] d);
        rsp_t r;
        case (op)
            c_READ: begin
                r.a = a; r.d = (a == 5'd0) ? 32'd0 : m_regs[a]; r.l = 1'b1;
                exp_q.push_back(r);
            end
            c_WRITE: if (a != 5'd0) m_regs[a] = d;
            c_DUMP: for (int k = 0; k < 32; k++) begin
                r.a = 5'(k); r.d = (k == 0) ? 32'd0 : m_regs[k]; r.l = (k == 31);
                exp_q.push_back(r);
            end
            default: for (int k = 1; k < 32; k++) m_regs[k] = 32'd0;
        endcase
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [4:0] a, input logic [31:0] d);
        int n = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d;
        while (!cmd_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            checks++; errors++;
            $display("FAIL cmd_accept: cmd_ready=%0b after %0d cycles, required 1", cmd_ready, n);
            cmd_valid = 1'b0;
            return;
        end
        model_cmd(op, a, d);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(cmd_ready && exp_q.size() == 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!(cmd_ready && exp_q.size() == 0)) begin
            errors++;
            $display("FAIL wait_idle: cmd_ready=%0b pending=%0d, required 1 and 0", cmd_ready, exp_q.size());
        end
    endtask

    task automatic preload();
        for (int k = 1; k < 32; k++) send_cmd(c_WRITE, 5'(k), 32'h100 + 32'(k));
        wait_idle();
    endtask

    task automatic count_busy(output int cnt, output bit rdy_seen);
        cnt = 0; rdy_seen = 0;
        for (int i = 0; i < 1000; i++) begin
            if (!busy) break;
            if (cmd_ready) rdy_seen = 1;
            cnt++;
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: pops an expectation on each response handshake, checks hold while stalled.
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                stall_prev = 0;
            end else begin
                if (stall_prev) begin
                    checks++;
                    if (!rsp_valid || rsp_addr != p_a || rsp_data != p_d || rsp_last != p_l) begin
                        errors++;
                        $display("FAIL rsp_stable: got v=%0b a=%0d d=%h l=%0b, required v=1 a=%0d d=%h l=%0b",
                                 rsp_valid, rsp_addr, rsp_data, rsp_last, p_a, p_d, p_l);
                    end
                end
                if (rsp_valid) begin
                    checks++;
                    if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
                        errors++;
                        $display("FAIL rsp_busy: cmd_ready=%0b busy=%0b, required 0 and 1", cmd_ready, busy);
                    end
                    if (rsp_ready) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL rsp_unexpected: got a=%0d d=%h, required no response", rsp_addr, rsp_data);
                        end else begin
                            e = exp_q.pop_front();
                            if (rsp_addr != e.a || rsp_data != e.d || rsp_last != e.l) begin
                                errors++;
                                $display("FAIL rsp_word: got a=%0d d=%h l=%0b, required a=%0d d=%h l=%0b",
                                         rsp_addr, rsp_data, rsp_last, e.a, e.d, e.l);
                            end
                        end
                    end
                end
                stall_prev = rsp_valid && !rsp_ready;
                p_a = rsp_addr; p_d = rsp_data; p_l = rsp_last;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  cnt;
        bit  flag, bad;
        logic [1:0]  op;
        logic [4:0]  a;
        logic [31:0] d;

        for (int k = 0; k < 32; k++) m_regs[k] = 32'd0;
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = '0; cmd_data = '0;
        #3;
        checks++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_last !== 1'b0 ||
            rsp_addr !== 5'd0 || rsp_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: busy=%0b rdy=%0b v=%0b l=%0b a=%0d d=%h, required 0 1 0 0 0 0",
                     busy, cmd_ready, rsp_valid, rsp_last, rsp_addr, rsp_data);
        end
        checks++;
        if (rf_we3 !== 1'b0 || rf_a1 !== 5'd0 || rf_a3 !== 5'd0 || rf_wd3 !== 32'd0) begin
            errors++;
            $display("FAIL reset_ports: we3=%0b a1=%0d a3=%0d wd3=%h, required all 0", rf_we3, rf_a1, rf_a3, rf_wd3);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // WRITE then READ with latency check
        send_cmd(c_WRITE, 5'd5, 32'hDEADBEEF);
        send_cmd(c_READ, 5'd5, 32'd0);
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL read_latency_early: rsp_valid=%0b one cycle after accept, required 0", rsp_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_addr !== 5'd5 || rsp_data !== 32'hDEADBEEF || rsp_last !== 1'b1) begin
            errors++;
            $display("FAIL read_latency: v=%0b a=%0d d=%h l=%0b, required 1 5 deadbeef 1",
                     rsp_valid, rsp_addr, rsp_data, rsp_last);
        end
        wait_idle();

        // DUMP at full rate: 64 busy cycles
        preload();
        send_cmd(c_DUMP, 5'd0, 32'd0);
        count_busy(cnt, flag);
        checks++;
        if (cnt != 64 || flag) begin
            errors++;
            $display("FAIL dump_busy: busy cycles=%0d cmd_ready_seen=%0b, required 64 and 0", cnt, flag);
        end
        wait_idle();

        // DUMP with random backpressure
        rdy_rand = 1;
        send_cmd(c_DUMP, 5'd0, 32'd0);
        count_busy(cnt, flag);
        checks++;
        if (cnt < 64 || flag) begin
            errors++;
            $display("FAIL dump_stall_busy: busy cycles=%0d cmd_ready_seen=%0b, required >=64 and 0", cnt, flag);
        end
        wait_idle();
        rdy_rand = 0;

        // CLEAR: 31 writes of zero to 1..31, then an all-zero DUMP
        send_cmd(c_CLEAR, 5'd0, 32'd0);
        cnt = 0; bad = 0;
        for (int i = 0; i < 100; i++) begin
            if (!busy) break;
            if (rf_we3) begin
                if (rf_a3 != 5'(cnt + 1) || rf_wd3 != 32'd0) bad = 1;
                cnt++;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (cnt != 31 || bad) begin
            errors++;
            $display("FAIL clear_writes: we3 cycles=%0d seq_error=%0b, required 31 and 0", cnt, bad);
        end
        send_cmd(c_DUMP, 5'd0, 32'd0);
        wait_idle();

        // Reset in the middle of CLEAR at idx 10
        preload();
        send_cmd(c_CLEAR, 5'd0, 32'd0);
        for (int i = 0; i < 100; i++) begin
            if (rf_we3 && rf_a3 == 5'd10) break;
            @(posedge clk);
            #1;
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || rf_we3 !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_clear: busy=%0b we3=%0b rdy=%0b, required 0 0 1", busy, rf_we3, cmd_ready);
        end
        for (int k = 1; k < 32; k++) m_regs[k] = (k < 10) ? 32'd0 : 32'h100 + 32'(k);
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        send_cmd(c_DUMP, 5'd0, 32'd0);
        wait_idle();

        // Randomized command mix, READ of the top register included
        send_cmd(c_READ, 5'd31, 32'd0);
        for (int n = 0; n < 40; n++) begin
            rdy_rand = 1'($urandom_range(0, 1));
            op = 2'($urandom_range(0, 9) < 4 ? 0 : $urandom_range(0, 9) < 6 ? 1 : $urandom_range(2, 3));
            a  = 5'($urandom_range(0, 31));
            d  = $urandom;
            send_cmd(op, a, d);
        end
        send_cmd(c_DUMP, 5'd0, 32'd0);
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
